// File: rtl/soa_pkg.sv
// Shared sizing helpers and arithmetic functions for the pipelined set-one adder.
package soa_pkg;

    function automatic int dw_of(input int log2_width);
        return log2_width + (2 ** log2_width) - 1;
    endfunction

    function automatic int kw_of(input int log2_width);
        return log2_width + 1;
    endfunction

    // Callers zero-extend their counter into 32 bits and pass the saturation ceiling.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[31:0];
    endfunction

    function automatic logic [31:0] popcount(input logic [31:0] flags);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + {31'b0, flags[i]};
        return n;
    endfunction

endpackage

// File: rtl/soa_lane.sv
// One set-one adder lane: forces m LSBs to one and adds the upper bits with a carry-in.
module soa_lane
    import soa_pkg::*;
#(
    parameter int LOG2_WIDTH = 4,
    parameter int MSEL_W     = 4,
    localparam int WIDTH     = 2 ** LOG2_WIDTH,
    localparam int DW        = dw_of(LOG2_WIDTH),
    localparam int KW        = kw_of(LOG2_WIDTH)
) (
    input  logic [DW-1:0]     op1,
    input  logic [DW-1:0]     op2,
    input  logic [MSEL_W-1:0] m,
    input  logic              cin,
    output logic [WIDTH-2:0]  x,
    output logic [KW-1:0]     k,
    output logic              mismatch
);

    localparam int SW = DW + 1;

    logic [SW-1:0] a_ext;
    logic [SW-1:0] b_ext;
    logic [SW-1:0] exact;
    logic [SW-1:0] approx;
    logic [SW-1:0] low_mask;

    assign a_ext    = {1'b0, op1};
    assign b_ext    = {1'b0, op2};
    assign exact    = a_ext + b_ext;
    assign low_mask = ~({SW{1'b1}} << m);

    // cin is always 0 when m = 0, so this collapses to the exact sum.
    assign approx   = (((a_ext >> m) + (b_ext >> m) + SW'(cin)) << m) | low_mask;

    assign x        = approx[WIDTH-2:0];
    assign k        = approx[SW-1:WIDTH-1];
    assign mismatch = (approx != exact);

endmodule

// File: rtl/soa_pipe.sv
// Two-stage, multi-lane set-one adder with valid/ready handshake and accuracy counters.
module soa_pipe
    import soa_pkg::*;
#(
    parameter int LOG2_WIDTH = 4,
    parameter int WIDTH      = 2 ** LOG2_WIDTH,
    parameter int LANES      = 2,
    parameter int M_MAX      = 8,
    parameter int MSEL_W     = 4,
    parameter int CNT_W      = 16,
    localparam int DW        = dw_of(LOG2_WIDTH),
    localparam int KW        = kw_of(LOG2_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DW-1:0]      op1,
    input  logic [LANES*DW-1:0]      op2,
    input  logic [MSEL_W-1:0]        m_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*(WIDTH-1)-1:0] x_out,
    output logic [LANES*KW-1:0]      k_out,
    input  logic                     clr_cnt,
    output logic [CNT_W-1:0]         txn_cnt,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic                         s1_valid;
    logic [MSEL_W-1:0]            s1_m;
    logic [LANES*DW-1:0]          s1_op1;
    logic [LANES*DW-1:0]          s1_op2;
    logic [LANES-1:0]             s1_cin;

    logic                         s2_valid;
    logic [LANES*(WIDTH-1)-1:0]   s2_x;
    logic [LANES*KW-1:0]          s2_k;
    logic [LANES-1:0]             s2_mis;

    logic [MSEL_W-1:0]            m_eff;
    logic [LANES-1:0]             cin_d;
    logic [LANES*(WIDTH-1)-1:0]   lane_x;
    logic [LANES*KW-1:0]          lane_k;
    logic [LANES-1:0]             lane_mis;

    logic s2_load;
    logic accept;
    logic emit;

    assign s2_load  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;
    assign emit     = s2_valid && out_ready;

    assign out_valid = s2_valid;
    assign x_out     = s2_x;
    assign k_out     = s2_k;

    assign m_eff = (m_sel > MSEL_W'(M_MAX)) ? MSEL_W'(M_MAX) : m_sel;

    always_comb begin
        // NOTE: default first so every path assigns cin_d and no latch is inferred.
        cin_d = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int j = 1; j <= M_MAX; j++) begin
                if (m_eff == MSEL_W'(j)) cin_d[l] = op1[l*DW + j - 1] & op2[l*DW + j - 1];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst)           s1_valid <= 1'b0;
        else if (in_ready) s1_valid <= in_valid;
    end

    // NOTE: stage-1 payload is not reset; s1_valid qualifies it, so reset adds nothing.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_m   <= m_eff;
            s1_op1 <= op1;
            s1_op2 <= op2;
            s1_cin <= cin_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        soa_lane #(
            .LOG2_WIDTH (LOG2_WIDTH),
            .MSEL_W     (MSEL_W)
        ) u_lane (
            .op1      (s1_op1[l*DW +: DW]),
            .op2      (s1_op2[l*DW +: DW]),
            .m        (s1_m),
            .cin      (s1_cin[l]),
            .x        (lane_x[l*(WIDTH-1) +: (WIDTH-1)]),
            .k        (lane_k[l*KW +: KW]),
            .mismatch (lane_mis[l])
        );
    end

    // Output data only moves when a new bundle replaces it, so it holds during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_x     <= '0;
            s2_k     <= '0;
            s2_mis   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_x   <= lane_x;
                s2_k   <= lane_k;
                s2_mis <= lane_mis;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            txn_cnt <= '0;
            err_cnt <= '0;
        end else if (emit) begin
            txn_cnt <= CNT_W'(sat_add(32'(txn_cnt), 32'(LANES), CNT_MAX));
            err_cnt <= CNT_W'(sat_add(32'(err_cnt), popcount(32'(s2_mis)), CNT_MAX));
        end
    end

endmodule
